chacha20_stream_xor: RTL
========================

# chacha20_stream_xor

Parametrised ChaCha20 stream-combining stage. It takes 512-bit keystream blocks from the ChaCha20 core, XORs them lane by lane with an incoming plaintext stream, and emits ciphertext lanes with valid/ready, last and done flags. It is the generalised successor of the board-level per-character output (byte-valid strobe plus message-done flag). It sits between the core's block output and any consumer: LED/UART driver, capture bench or DMA.

## Interface
- `DATA_W`, 8: lane width in bits; legal values 8, 16, 32, 64 (must divide 512).
- `LEN_W`, 16: width of the message-length counter, in lanes.
- `CLOCK_50` in 1: single clock, rising edge.
- `KEY` in 1: `KEY[0]` is the reset; asynchronous, active-low.
- `start` in 1: one-cycle request to begin a message; sampled only in IDLE.
- `msg_len` in LEN_W: message length in lanes; latched on accepted `start`.
- `ctr_init` in 32: first block counter; latched on accepted `start`.
- `ks_req` out 1: request a keystream block for counter `ks_ctr`.
- `ks_ctr` out 32: block counter of the requested block.
- `ks_valid` in 1: `ks_block` valid; honoured only while `ks_req`=1.
- `ks_block` in 512: keystream block. Lane i = `ks_block[i*DATA_W +: DATA_W]` (little-endian byte order).
- `pt_data` in DATA_W, `pt_valid` in 1, `pt_ready` out 1: plaintext stream.
- `ct_data` out DATA_W, `ct_valid` out 1, `ct_ready` in 1, `ct_last` out 1: ciphertext stream.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at message end.

## Operation
- LANES = 512/DATA_W. Counters: `lane_idx` (0..LANES-1), `remaining` (LEN_W bits), `ks_ctr`.
- States: IDLE, REQ, XOR, DRAIN, DONE.
- IDLE, `start`=1:
  - `msg_len`=0 → DONE.
  - Otherwise latch `msg_len` and `ctr_init`, go to REQ.
  - `start` in any other state is ignored.
- REQ: `ks_req`=1. On `ks_valid`, capture block, clear `lane_idx`, go to XOR. `ks_req` drops the following cycle.
- XOR:
  - `pt_ready` = !`ct_valid` || `ct_ready`.
  - On a pt beat: `ct_data` <= `pt_data` ^ lane[`lane_idx`]; `ct_valid`<=1; `ct_last`<=(`remaining`==1); decrement `remaining`; increment `lane_idx`.
  - After the last lane of the message → DRAIN.
  - Else if `lane_idx` wraps LANES-1→0: `ks_ctr`+1 (modulo 2^32), go to REQ.
- DRAIN: wait for the `ct_last` beat to be accepted (`ct_valid`&&`ct_ready`), then → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `ct_valid` falls after an accepted beat when no new pt beat arrives in the same cycle.
- Output register holds `ct_data`/`ct_last` stable while `ct_valid`&&!`ct_ready`.

## Timing
- Reset values (async): all outputs 0 (`ks_req`, `ks_ctr`, `pt_ready`, `ct_data`, `ct_valid`, `ct_last`, `busy`, `done`); state IDLE; internal block buffer(s) cleared.
- `start` at cycle t: `ks_req`=1 from t+1 with `ks_ctr`=`ctr_init`.
- `ks_valid` at cycle r: `pt_ready` may rise at r+1.
- pt→ct latency: 1 cycle, full throughput of 1 lane/cycle within a block.
- Block boundary without prefetch: minimum 2-cycle bubble (REQ entry plus `ks_valid` response).
- `done` rises 1 cycle after the last ct handshake.
- `msg_len`=0: `done` at t+1 and t+1 only; `ks_req` never asserted.
- Simultaneous ct accept and new pt beat in XOR: both occur, with no bubble.
- `KEY[0]` low mid-message: immediate abort, all outputs 0. A new `start` is required afterwards.

## Configuration
- `CHACHA20_KS_PREFETCH_EN`:
  - Defined: adds a 512-bit shadow buffer.
    - `ks_req` for `ks_ctr`+1 asserts once the active block is loaded and `remaining` > lanes left in the active block.
    - At wrap, shadow→active in the same cycle with no bubble. If the shadow is not yet valid, enter REQ.
  - Undefined: single buffer; behaviour exactly as above.

## Structure
- `chacha20_pkg`:
  - `BLOCK_W`=512.
  - State enum (IDLE, REQ, XOR, DRAIN, DONE).
  - `lanes(DATA_W)` function.
  - Lane extraction function.
- Sub-module `chacha20_ks_buffer`: active/shadow block storage, valid bits and lane mux. The shadow buffer is generated only under `CHACHA20_KS_PREFETCH_EN`.

## Test plan
- DATA_W=8, `msg_len`=27, `ctr_init`=1, every `ks_block` byte 0xA5, pt="Hello..."(27 chars) → `ct_data`=pt^0xA5 per byte, `ct_last` on beat 27 only, `done` one cycle later, exactly one `ks_req` with `ks_ctr`=1.
- DATA_W=8, `msg_len`=65, `ctr_init`=7 → two requests, `ks_ctr`=7 then 8. Beat 65 uses byte 0 of block 8. With prefetch, no `pt_ready` gap between beats 64 and 65.
- `msg_len`=0 → `done`=1 at t+1 only, `ks_req` stays 0, `busy` high for 1 cycle.
- `ct_ready` low for 5 cycles mid-message → `ct_data`/`ct_last` stable, `pt_ready`=0 throughout, no lane skipped or duplicated.
- DATA_W=32, `ks_block` = byte index pattern (byte n = n), pt=0 → ct lane 0 = 0x03020100, lane 15 = 0x3F3E3D3C.
- Assert `KEY[0]`=0 after beat 10 of 40, release, restart with `msg_len`=4 → all outputs 0 during reset. New message starts from `ctr_init`, with correct 4 beats and `done`.

Source files
------------

// File: rtl/chacha20_pkg.sv
// chacha20_pkg: block width, FSM state type and lane helpers for the ChaCha20 stream-combining stage.
package chacha20_pkg;

    localparam int BLOCK_W = 512;

    typedef enum logic [2:0] {IDLE, REQ, XOR, DRAIN, DONE} state_t;

    function automatic int lanes(input int data_w);
        return BLOCK_W / data_w;
    endfunction

    // Returns the 64 bits starting at lane idx; callers truncate to their lane width.
    function automatic logic [63:0] lane_of(input logic [BLOCK_W-1:0] blk, input int idx, input int data_w);
        logic [BLOCK_W-1:0] s;
        s = blk >> (idx * data_w);
        return s[63:0];
    endfunction

endpackage

// File: rtl/chacha20_ks_buffer.sv
// chacha20_ks_buffer: active keystream block with lane mux; CHACHA20_KS_PREFETCH_EN adds a shadow block
// that is promoted to active on lane wrap.
module chacha20_ks_buffer
    import chacha20_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               adv,
    input  logic [BLOCK_W-1:0] block,
    input  logic [IDX_W-1:0]   lane_idx,
    output logic               act_valid,
    output logic               sh_valid,
    output logic               next_ready,
    output logic [DATA_W-1:0]  lane
);

    logic [BLOCK_W-1:0] act;

    assign lane = DATA_W'(lane_of(act, int'(lane_idx), DATA_W));

`ifdef CHACHA20_KS_PREFETCH_EN
    logic [BLOCK_W-1:0] sh;

    // A block arriving on the wrap cycle itself goes straight to active.
    assign next_ready = sh_valid || load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= '0;
            sh        <= '0;
            act_valid <= 1'b0;
            sh_valid  <= 1'b0;
        end else if (clr) begin
            act_valid <= 1'b0;
            sh_valid  <= 1'b0;
        end else if (adv) begin
            act       <= sh_valid ? sh : block;
            act_valid <= sh_valid || load;
            sh_valid  <= 1'b0;
        end else if (load && act_valid) begin
            sh       <= block;
            sh_valid <= 1'b1;
        end else if (load) begin
            act       <= block;
            act_valid <= 1'b1;
        end
    end
`else
    assign sh_valid   = 1'b0;
    assign next_ready = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= '0;
            act_valid <= 1'b0;
        end else if (clr || adv) begin
            act_valid <= 1'b0;
        end else if (load) begin
            act       <= block;
            act_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/chacha20_stream_xor.sv
// chacha20_stream_xor: XORs 512-bit ChaCha20 keystream blocks lane by lane onto a plaintext stream.
// Define CHACHA20_KS_PREFETCH_EN to fetch the next block into a shadow buffer while the current one drains.
module chacha20_stream_xor
    import chacha20_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic               CLOCK_50,
    input  logic [0:0]         KEY,
    input  logic               start,
    input  logic [LEN_W-1:0]   msg_len,
    input  logic [31:0]        ctr_init,
    output logic               ks_req,
    output logic [31:0]        ks_ctr,
    input  logic               ks_valid,
    input  logic [BLOCK_W-1:0] ks_block,
    input  logic [DATA_W-1:0]  pt_data,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic [DATA_W-1:0]  ct_data,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic               ct_last,
    output logic               busy,
    output logic               done
);

    localparam int LANES = lanes(DATA_W);
    localparam int IDX_W = $clog2(LANES);
`ifdef CHACHA20_KS_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    state_t            state, state_nx;
    logic              rst_n;
    logic [LEN_W-1:0]  remaining;
    logic [IDX_W-1:0]  lane_idx;
    logic [31:0]       blk_ctr;
    logic [DATA_W-1:0] lane;
    logic              act_valid, sh_valid, next_ready;
    logic              pf_req, load, clr, pt_fire, ct_fire, last_beat, wrap;

    assign rst_n     = KEY[0];
    assign pt_fire   = pt_valid && pt_ready;
    assign ct_fire   = ct_valid && ct_ready;
    assign last_beat = pt_fire && remaining == LEN_W'(1);
    assign wrap      = pt_fire && !last_beat && lane_idx == IDX_W'(LANES - 1);
    assign clr       = state == IDLE && start;
    // blk_ctr tracks the active block; a prefetch asks for the one after it.
    assign pf_req    = PF_EN && state == XOR && act_valid && !sh_valid &&
                       32'(remaining) > 32'(LANES) - 32'(lane_idx);
    assign ks_req    = state == REQ || pf_req;
    assign ks_ctr    = blk_ctr + 32'(pf_req);
    assign load      = ks_valid && ks_req;
    assign pt_ready  = state == XOR && act_valid && (!ct_valid || ct_ready);
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    chacha20_ks_buffer #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_buf (
        .clk        (CLOCK_50),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .adv        (wrap),
        .block      (ks_block),
        .lane_idx   (lane_idx),
        .act_valid  (act_valid),
        .sh_valid   (sh_valid),
        .next_ready (next_ready),
        .lane       (lane)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = msg_len == '0 ? DONE : REQ;
            REQ:     if (load) state_nx = XOR;
            XOR:     if (last_beat) state_nx = DRAIN;
                     else if (wrap) state_nx = next_ready ? XOR : REQ;
            DRAIN:   if (ct_fire) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            lane_idx  <= '0;
            blk_ctr   <= '0;
            ct_data   <= '0;
            ct_valid  <= 1'b0;
            ct_last   <= 1'b0;
        end else begin
            state <= state_nx;
            if (clr && msg_len != '0) begin
                remaining <= msg_len;
                blk_ctr   <= ctr_init;
            end
            if (state == REQ && load)
                lane_idx <= '0;
            if (wrap)
                blk_ctr <= blk_ctr + 32'd1;
            // The output register only moves on a new beat, so it holds while stalled.
            if (pt_fire) begin
                remaining <= remaining - 1'b1;
                lane_idx  <= lane_idx + 1'b1;
                ct_data   <= pt_data ^ lane;
                ct_valid  <= 1'b1;
                ct_last   <= remaining == LEN_W'(1);
            end else if (ct_fire) begin
                ct_valid <= 1'b0;
                ct_last  <= 1'b0;
            end
        end
    end

endmodule
